prg_scan_seq: RTL and testbench



---
 rtl/prg_scan_seq.sv | 159 +++++++++++++++
 tb/tb_prg_scan_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_scan_seq.sv
// Pixel/sample scan sequencer: walks a frame in raster or tiled order, one record per accept.
// Define PRG_SCAN_JITTER_EN to drive sub-pixel offsets from a 16-bit LFSR instead of centre.
module prg_scan_seq #(
    parameter int W_PIX    = 640,
    parameter int H_PIX    = 480,
    parameter int SPP_LOG2 = 0,
    parameter int TILE     = 8,
    parameter int ID_W     = $clog2(W_PIX * H_PIX),
    localparam int XW      = $clog2(W_PIX),
    localparam int YW      = $clog2(H_PIX),
    localparam int SW      = (SPP_LOG2 > 0) ? SPP_LOG2 : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            tile_mode,
    input  logic            int_to_prg_stall,
    output logic            rayReady,
    output logic [ID_W-1:0] pixelID,
    output logic [XW-1:0]   px,
    output logic [YW-1:0]   py,
    output logic [SW-1:0]   sample,
    output logic [3:0]      sub_x,
    output logic [3:0]      sub_y,
    output logic            idle,
    output logic            done
);

    if ((W_PIX % TILE) != 0 || (H_PIX % TILE) != 0 || SPP_LOG2 > 4 ||
        (TILE & (TILE - 1)) != 0) begin : g_param_err
        $error("prg_scan_seq: illegal parameter combination");
    end

    localparam logic [XW-1:0]   X_MAX    = XW'(W_PIX - 1);
    localparam logic [YW-1:0]   Y_MAX    = YW'(H_PIX - 1);
    localparam logic [SW-1:0]   S_MAX    = SW'((1 << SPP_LOG2) - 1);
    localparam logic [XW-1:0]   X_TM     = XW'(TILE - 1);
    localparam logic [YW-1:0]   Y_TM     = YW'(TILE - 1);
    localparam logic [ID_W-1:0] PID_DOWN = ID_W'(W_PIX - TILE + 1);
    localparam logic [ID_W-1:0] PID_BACK = ID_W'((TILE - 1) * W_PIX - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          r_state, w_state_nxt;
    logic            r_tile;
    logic [ID_W-1:0] r_pid, w_pid_nxt;
    logic [XW-1:0]   r_px, w_px_nxt;
    logic [YW-1:0]   r_py, w_py_nxt;
    logic [SW-1:0]   r_sample, w_sample_nxt;
    logic            w_acc, w_s_last, w_x_end, w_y_end, w_lx_last, w_ly_last, w_last;
    logic [3:0]      w_sub_x_src, w_sub_y_src;

    assign w_acc     = (r_state == StRun) && !int_to_prg_stall;
    assign w_s_last  = (r_sample == S_MAX);
    assign w_x_end   = (r_px == X_MAX);
    assign w_y_end   = (r_py == Y_MAX);
    assign w_lx_last = ((r_px & X_TM) == X_TM);
    assign w_ly_last = ((r_py & Y_TM) == Y_TM);
    assign w_last    = w_s_last && w_x_end && w_y_end;

    // Tiled order moves pixelID by fixed strides so no multiplier is needed.
    always_comb begin
        w_px_nxt     = r_px;
        w_py_nxt     = r_py;
        w_pid_nxt    = r_pid;
        w_sample_nxt = w_s_last ? '0 : r_sample + 1'b1;
        if (w_s_last) begin
            if (!r_tile || !w_lx_last) begin
                if (!r_tile && w_x_end) begin
                    w_px_nxt = '0;
                    w_py_nxt = r_py + 1'b1;
                end else begin
                    w_px_nxt = r_px + 1'b1;
                end
                w_pid_nxt = r_pid + 1'b1;
            end else if (!w_ly_last) begin
                w_px_nxt  = r_px - X_TM;
                w_py_nxt  = r_py + 1'b1;
                w_pid_nxt = r_pid + PID_DOWN;
            end else if (!w_x_end) begin
                w_px_nxt  = r_px + 1'b1;
                w_py_nxt  = r_py - Y_TM;
                w_pid_nxt = r_pid - PID_BACK;
            end else begin
                w_px_nxt  = '0;
                w_py_nxt  = r_py + 1'b1;
                w_pid_nxt = r_pid + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_nxt = StRun;
            StRun:   if (w_acc && w_last) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_tile   <= 1'b0;
            r_pid    <= '0;
            r_px     <= '0;
            r_py     <= '0;
            r_sample <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StIdle && start) begin
                r_tile   <= tile_mode;
                r_pid    <= '0;
                r_px     <= '0;
                r_py     <= '0;
                r_sample <= '0;
            end else if (w_acc && !w_last) begin
                r_pid    <= w_pid_nxt;
                r_px     <= w_px_nxt;
                r_py     <= w_py_nxt;
                r_sample <= w_sample_nxt;
            end
        end
    end

`ifdef PRG_SCAN_JITTER_EN
    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else if (w_acc) begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

    assign w_sub_x_src = r_lfsr[3:0];
    assign w_sub_y_src = r_lfsr[7:4];
`else
    assign w_sub_x_src = 4'h8;
    assign w_sub_y_src = 4'h8;
`endif

    assign rayReady = (r_state == StRun);
    assign idle     = (r_state == StIdle);
    assign done     = (r_state == StDone);
    assign pixelID  = r_pid;
    assign px       = r_px;
    assign py       = r_py;
    assign sample   = r_sample;
    // Offsets read as zero outside a frame so reset/idle outputs are all clear.
    assign sub_x    = rayReady ? w_sub_x_src : 4'h0;
    assign sub_y    = rayReady ? w_sub_y_src : 4'h0;

endmodule

// File: tb/tb_prg_scan_seq.sv
// Scoreboard bench for prg_scan_seq on a 4x2 frame, 2x2 tiles, 2 samples per pixel.
// Build with PRG_SCAN_JITTER_EN defined to check the LFSR offsets as well.
module tb_prg_scan_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       tile_mode = 1'b0;
    logic       stall = 1'b0;
    logic       rayReady, idle, done;
    logic [2:0] pixelID;
    logic [1:0] px;
    logic [0:0] py;
    logic [0:0] sample;
    logic [3:0] sub_x, sub_y;

    prg_scan_seq #(
        .W_PIX(4), .H_PIX(2), .SPP_LOG2(1), .TILE(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tile_mode(tile_mode),
        .int_to_prg_stall(stall), .rayReady(rayReady), .pixelID(pixelID),
        .px(px), .py(py), .sample(sample), .sub_x(sub_x), .sub_y(sub_y),
        .idle(idle), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {int pid; int s; bit last;} rec_t;

    rec_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          n_acc = 0;
    int          n_done = 0;
    int          chk_state = 0;
    int          exp_done = 0;
    int          tiled_ord[8] = '{0, 1, 4, 5, 2, 3, 6, 7};
    logic [15:0] m_lfsr = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    // Monitor: compare the presented record with the head of the queue; pop on acceptance.
    always @(negedge clk) begin
        rec_t       e;
        logic [3:0] esx, esy;
        if (rst) begin
            m_lfsr = 16'hACE1;
        end else begin
            if (chk_state == 1) begin
                checks++;
                if (!(done === 1'b1 && rayReady === 1'b0)) begin
                    errors++;
                    $display("FAIL done_pulse: done=%b rayReady=%b, need done=1 rayReady=0",
                             done, rayReady);
                end
                chk_state = 2;
            end else if (chk_state == 2) begin
                checks++;
                if (!(idle === 1'b1 && done === 1'b0)) begin
                    errors++;
                    $display("FAIL idle_return: idle=%b done=%b, need idle=1 done=0", idle, done);
                end
                chk_state = 0;
            end
            if (done === 1'b1) n_done++;
            if (rayReady === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_record: pid=%0d sample=%0d, need no record", pixelID,
                             sample);
                end else begin
                    e = q[0];
`ifdef PRG_SCAN_JITTER_EN
                    esx = m_lfsr[3:0];
                    esy = m_lfsr[7:4];
`else
                    esx = 4'h8;
                    esy = 4'h8;
`endif
                    if (pixelID !== 3'(e.pid) || px !== 2'(e.pid % 4) || py !== 1'(e.pid / 4) ||
                        sample !== 1'(e.s) || sub_x !== esx || sub_y !== esy || done !== 1'b0)
                    begin
                        errors++;
                        $display({"FAIL record: got pid=%0d px=%0d py=%0d s=%0d sx=%h sy=%h ",
                                  "done=%b, need pid=%0d px=%0d py=%0d s=%0d sx=%h sy=%h ",
                                  "done=0 (stall=%b)"},
                                 pixelID, px, py, sample, sub_x, sub_y, done, e.pid, e.pid % 4,
                                 e.pid / 4, e.s, esx, esy, stall);
                    end
                    if (!stall) begin
                        void'(q.pop_front());
                        n_acc++;
                        m_lfsr = lfsr_step(m_lfsr);
                        if (e.last) chk_state = 1;
                    end
                end
            end
        end
    end

    task automatic start_frame(input bit tm);
        @(posedge clk);
        #1;
        start     = 1'b1;
        tile_mode = tm;
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < 2; s++) begin
                q.push_back('{pid: (tm ? tiled_ord[k] : k), s: s, last: (k == 7 && s == 1)});
            end
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        tile_mode = ~tm;
    endtask

    task automatic wait_frame(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && chk_state == 0 && idle === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_complete: left=%0d idle=%b, need left=0 idle=1", name, q.size(),
                     idle);
        end
        exp_done++;
    endtask

    initial begin
        int base;
        bit ok;
        #1;
        checks++;
        if (!(idle === 1'b1 && rayReady === 1'b0 && done === 1'b0 && pixelID === 3'd0 &&
              sample === 1'b0 && sub_x === 4'h0 && sub_y === 4'h0)) begin
            errors++;
            $display("FAIL reset_state: idle=%b rdy=%b done=%b pid=%0d sx=%h, need 1 0 0 0 0",
                     idle, rayReady, done, pixelID, sub_x);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        start_frame(1'b0);
        wait_frame("raster");

        start_frame(1'b1);
        wait_frame("tiled");

        start_frame(1'b0);
        repeat (4) @(posedge clk);
        #1;
        stall = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        stall = 1'b0;
        wait_frame("stall");

        // Abort a frame with reset after the fifth acceptance.
        base = n_acc;
        start_frame(1'b1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (n_acc >= base + 5) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_wait: acc=%0d, need %0d", n_acc - base, 5);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!(rayReady === 1'b0 && idle === 1'b1 && done === 1'b0 && pixelID === 3'd0)) begin
            errors++;
            $display("FAIL midframe_reset: rdy=%b idle=%b done=%b pid=%0d, need 0 1 0 0",
                     rayReady, idle, done, pixelID);
        end
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start_frame(1'b0);
        wait_frame("restart");

        // A start pulse mid-frame must not restart the scan.
        start_frame(1'b0);
        repeat (3) @(posedge clk);
        #1;
        start     = 1'b1;
        tile_mode = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_frame("start_ignored");

        // Stall raised while the final record is presented holds off completion.
        start_frame(1'b1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 1) begin
                ok = 1'b1;
                break;
            end
        end
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!(ok && rayReady === 1'b1 && done === 1'b0 && pixelID === 3'd7)) begin
            errors++;
            $display("FAIL last_stall: found=%b rdy=%b done=%b pid=%0d, need 1 1 0 7", ok,
                     rayReady, done, pixelID);
        end
        stall = 1'b0;
        wait_frame("last_stall");

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (n_done != exp_done) begin
            errors++;
            $display("FAIL done_count: got %0d pulses, need %0d", n_done, exp_done);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
